// File: rtl/fmul_share_arb_if.sv
// Signal bundle between the shared-multiplier arbiter and its requesters/multiplier.
// slave is the arbiter's view; master is the surrounding environment.
interface fmul_share_arb_if #(
  parameter int W    = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [2:0]        rsp_flag;
  logic [W-1:0]      mul_a_tdata;
  logic [W-1:0]      mul_b_tdata;
  logic              mul_a_tvalid;
  logic              mul_b_tvalid;
  logic              mul_a_tready;
  logic              mul_b_tready;
  logic [W-1:0]      mul_result_tdata;
  logic              mul_result_tvalid;
  logic [2:0]        mul_flag;
  logic              busy;
  logic              err_orphan;

  modport slave (
    input  req_valid, req_a, req_b,
    input  mul_a_tready, mul_b_tready, mul_result_tdata, mul_result_tvalid, mul_flag,
    output req_ready, rsp_valid, rsp_data, rsp_flag,
    output mul_a_tdata, mul_b_tdata, mul_a_tvalid, mul_b_tvalid,
    output busy, err_orphan
  );

  modport master (
    output req_valid, req_a, req_b,
    output mul_a_tready, mul_b_tready, mul_result_tdata, mul_result_tvalid, mul_flag,
    input  req_ready, rsp_valid, rsp_data, rsp_flag,
    input  mul_a_tdata, mul_b_tdata, mul_a_tvalid, mul_b_tvalid,
    input  busy, err_orphan
  );
endinterface

// File: rtl/fmul_share_arb.sv
// Round-robin sharing of one fp16 multiplier among NREQ requesters; an id FIFO
// tracks the owner of each in-flight operation so in-order results route back.
module fmul_share_arb #(
  parameter int EXP   = 5,
  parameter int FRA   = 10,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  fmul_share_arb_if.slave  bus
);
  localparam int W  = EXP + FRA + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int unsigned NREQ_U = NREQ;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);

  logic            iv;
  logic [W-1:0]    ia, ib;
  logic [IW-1:0]   iid, last;
  logic [IW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt, inflight;
  logic            handoff, slot_free, accept, pop, orphan;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            found;
  logic [IW-1:0]   lane;
  logic [NREQ-1:0] rsp_valid_q;
  logic [W-1:0]    rsp_data_q;
  logic [2:0]      rsp_flag_q;
  logic            err_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign handoff   = iv & bus.mul_a_tready & bus.mul_b_tready;
  // inflight already counts the issue register, so it alone bounds FIFO pushes
  assign slot_free = ~sys_rst & (~iv | handoff) & (inflight < DEPTH_C);
  assign pop       = bus.mul_result_tvalid & (fifo_cnt != '0);
  assign orphan    = bus.mul_result_tvalid & (fifo_cnt == '0);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    lane     = '0;
    if (slot_free) begin
      for (int unsigned k = 1; k <= NREQ_U; k++) begin
        lane = IW'((32'(last) + k) % NREQ_U);
        if (!found && bus.req_valid[lane]) begin
          found       = 1'b1;
          grant[lane] = 1'b1;
          grant_id    = lane;
        end
      end
    end
  end

  assign accept = found;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      iv   <= 1'b0;
      ia   <= '0;
      ib   <= '0;
      iid  <= '0;
      last <= LAST_RST;
    end else if (accept) begin
      iv   <= 1'b1;
      ia   <= bus.req_a[grant_id*W +: W];
      ib   <= bus.req_b[grant_id*W +: W];
      iid  <= grant_id;
      last <= grant_id;
    end else if (handoff) begin
      iv   <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (handoff) fifo_mem[wr_ptr] <= iid;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
    end else begin
      if (handoff) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({handoff, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (pop) begin
        rsp_valid_q <= NREQ'(1) << fifo_mem[rd_ptr];
        rsp_data_q  <= bus.mul_result_tdata;
        rsp_flag_q  <= bus.mul_flag;
      end
      if (orphan) err_q <= 1'b1;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.mul_a_tdata  = ia;
  assign bus.mul_b_tdata  = ib;
  assign bus.mul_a_tvalid = iv;
  assign bus.mul_b_tvalid = iv;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_flag     = rsp_flag_q;
  assign bus.busy         = iv | (inflight != '0);
  assign bus.err_orphan   = err_q;
endmodule

// File: tb/tb_fmul_share_arb.sv
// Randomized bench for fmul_share_arb: an in-order fp16 multiplier stand-in plus a
// queue-based model of grants, owners and responses checked every cycle.
module tb_fmul_share_arb;
  localparam int W = 16, NREQ = 4, DEPTH = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  fmul_share_arb_if #(.W(W), .NREQ(NREQ)) bus ();

  fmul_share_arb #(.EXP(5), .FRA(10), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int due; logic [15:0] d; logic [2:0] f; } mres_t;
  typedef struct { int lane; logic [15:0] d; logic [2:0] f; } tag_t;

  mres_t pipe[$];
  tag_t  tags[$];
  int    cyc = 0, lat = 3, last_due = -1;
  bit    pend;
  int    pend_lane;
  logic [15:0] pend_a, pend_b;
  int    outstanding, rr_last;
  logic [3:0]  exp_rv;
  logic [15:0] exp_rd;
  logic [2:0]  exp_rf;
  bit    exp_err;
  bit    inject = 0;
  int    obs_grant;
  logic [3:0]  obs_rv;
  logic [15:0] obs_rd;
  int    obs_acc_cnt = 0, obs_rsp_cnt = 0;
  int    vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Truncating fp16 product; flag = {overflow, underflow, zero operand}
  function automatic logic [18:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic s; int e; logic [21:0] p; logic [9:0] fr;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {3'b001, s, 15'd0};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin fr = p[20:11]; e++; end
    else fr = p[19:10];
    if (e >= 31) return {3'b100, s, 5'h1f, 10'd0};
    if (e <= 0)  return {3'b010, s, 15'd0};
    return {3'b000, s, e[4:0], fr};
  endfunction

  function automatic void model_reset();
    pend = 0; outstanding = 0; tags.delete(); rr_last = NREQ - 1;
    exp_rv = '0; exp_rd = '0; exp_rf = '0; exp_err = 0;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*16 +: 16] = 16'($urandom);
      bus.req_b[i*16 +: 16] = 16'($urandom);
    end
  endtask

  // One clock cycle: entered and left at a falling edge with inputs already set.
  task automatic step();
    logic [3:0] g; bit ho, res; mres_t r; tag_t t; int lane; logic [18:0] m;
    res = 0;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      r = pipe.pop_front();
      bus.mul_result_tvalid = 1'b1; bus.mul_result_tdata = r.d; bus.mul_flag = r.f; res = 1;
    end else if (inject) begin
      bus.mul_result_tvalid = 1'b1; bus.mul_result_tdata = 16'($urandom); bus.mul_flag = 3'($urandom); res = 1;
    end else begin
      bus.mul_result_tvalid = 1'b0; bus.mul_result_tdata = '0; bus.mul_flag = '0;
    end
    #1;
    obs_rv = bus.rsp_valid; obs_rd = bus.rsp_data;
    if (obs_rv != 0) obs_rsp_cnt++;
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv != 0) begin
      check("rsp_data", bus.rsp_data, exp_rd);
      check("rsp_flag", bus.rsp_flag, exp_rf);
    end
    check("err_orphan", bus.err_orphan, exp_err);
    check("mul_a_tvalid", bus.mul_a_tvalid, pend);
    check("mul_b_tvalid", bus.mul_b_tvalid, pend);
    if (pend) begin
      check("mul_a_tdata", bus.mul_a_tdata, pend_a);
      check("mul_b_tdata", bus.mul_b_tdata, pend_b);
    end
    check("busy", bus.busy, outstanding != 0);
    ho = pend && bus.mul_a_tready && bus.mul_b_tready;
    g = '0; lane = -1;
    if (!sys_rst && (!pend || ho) && outstanding < DEPTH)
      for (int k = 1; k <= NREQ; k++)
        if (lane < 0 && bus.req_valid[(rr_last + k) % NREQ]) lane = (rr_last + k) % NREQ;
    if (lane >= 0) g[lane] = 1'b1;
    check("req_ready", bus.req_ready, g);
    obs_grant = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs_grant = i;
    if (obs_grant >= 0) obs_acc_cnt++;
    if (!sys_rst) begin
      exp_rv = '0;
      if (res) begin
        if (tags.size() > 0) begin
          t = tags.pop_front();
          exp_rv = 4'(1) << t.lane; exp_rd = t.d; exp_rf = t.f; outstanding--;
        end else exp_err = 1;
      end
      if (ho) begin
        m = fmul(bus.mul_a_tdata, bus.mul_b_tdata);
        r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.d = m[15:0]; r.f = m[18:16];
        pipe.push_back(r); last_due = r.due;
        m = fmul(pend_a, pend_b);
        t.lane = pend_lane; t.d = m[15:0]; t.f = m[18:16];
        tags.push_back(t); pend = 0;
      end
      if (lane >= 0) begin
        pend = 1; pend_lane = lane;
        pend_a = bus.req_a[lane*16 +: 16]; pend_b = bus.req_b[lane*16 +: 16];
        outstanding++; rr_last = lane;
      end
    end
    @(posedge sys_clk); cyc++;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; bus.req_valid = '1;
    #1;
    model_reset();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_flag", bus.rsp_flag, 0);
    check("rst_tvalid", {bus.mul_a_tvalid, bus.mul_b_tvalid}, 0);
    check("rst_tdata", {bus.mul_a_tdata, bus.mul_b_tdata}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_orphan, 0);
    bus.req_valid = '0;
    step(); step();
    sys_rst = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0; bus.mul_a_tready = 1'b1; bus.mul_b_tready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, acc, base; bit got;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.mul_a_tready = 1'b1; bus.mul_b_tready = 1'b1;
    bus.mul_result_tvalid = 1'b0; bus.mul_result_tdata = '0; bus.mul_flag = '0;
    model_reset();
    #2 sys_rst = 1'b1;
    @(negedge sys_clk);
    do_reset();

    // single op on lane 0
    lat = 3;
    bus.req_a[15:0] = 16'h3c00; bus.req_b[15:0] = 16'h4000; bus.req_valid = 4'b0001;
    step();
    check("single_grant", obs_grant, 0);
    bus.req_valid = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (obs_rv != 0) got = 1;
    end
    check("single_seen", got, 1);
    check("single_rv", obs_rv, 4'b0001);
    check("single_rd", obs_rd, 16'h4000);
    step();
    check("single_pulse", obs_rv, 0);
    check("single_busy", bus.busy, 0);

    // round robin from reset, all lanes requesting
    do_reset();
    bus.req_valid = '1; acc = 0;
    for (int i = 0; i < 40 && acc < 8; i++) begin
      rand_ops();
      bus.req_a[32 +: 16] = 16'h2e66; bus.req_b[32 +: 16] = 16'h068e;
      step();
      if (obs_grant >= 0) begin
        check("rr_order", obs_grant, acc % NREQ);
        acc++;
      end
    end
    check("rr_accepts", acc, 8);
    drain(15);

    // credit limit with a slow multiplier
    lat = 10; bus.req_valid = '1; n = 0;
    repeat (10) begin rand_ops(); step(); if (obs_grant >= 0) n++; end
    check("credit_accepts", n, DEPTH);
    repeat (30) begin rand_ops(); step(); end
    drain(25);

    // multiplier ready stall
    lat = 3; bus.req_valid = 4'b0100; rand_ops();
    step();
    check("stall_first", obs_grant, 2);
    bus.mul_b_tready = 1'b0; n = 0;
    repeat (5) begin rand_ops(); step(); if (obs_grant >= 0) n++; end
    check("stall_grants", n, 0);
    bus.mul_b_tready = 1'b1;
    step();
    check("stall_regrant", obs_grant, 2);
    drain(10);

    // sustained traffic at the inflight bound
    lat = 3; bus.req_valid = '1; base = obs_acc_cnt - obs_rsp_cnt;
    repeat (60) begin
      rand_ops(); step();
      check("inflight_bound", (obs_acc_cnt - obs_rsp_cnt - base) <= DEPTH, 1);
    end
    drain(15);

    // randomized traffic and readiness
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 8);
      bus.req_valid = 4'($urandom);
      bus.mul_a_tready = ($urandom_range(0, 3) != 0);
      bus.mul_b_tready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    drain(40);

    // reset with operations in flight, then late and injected results
    lat = 10; bus.req_valid = '1;
    repeat (3) begin rand_ops(); step(); end
    bus.req_valid = '0;
    repeat (2) step();
    check("orphan_pre_busy", bus.busy, 1);
    do_reset();
    for (int i = 0; i < 20 && pipe.size() > 0; i++) step();
    check("orphan_drained", pipe.size(), 0);
    check("orphan_set", bus.err_orphan, 1);
    inject = 1; step(); inject = 0;
    step();
    check("orphan_sticky", bus.err_orphan, 1);
    do_reset();
    check("orphan_cleared", bus.err_orphan, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fmul_share_arb.md
# fmul_share_arb

Round-robin arbiter and sequencer that shares one half-precision floating-point multiplier among NREQ requesters. It sits between the per-lane compute units and a single multiplier instance with AXI-stream-style ports. It issues operand pairs in round-robin order and tracks the owner of each in-flight operation. It routes each in-order result, with its 3-bit flag, back to the requester that issued it.

## Interface
- EXP, 5, exponent width
- FRA, 10, stored fraction width; operand/result width W = EXP+FRA+1 (16)
- NREQ, 4, number of requesters (2..8)
- DEPTH, 4, max operations in flight, issue register included; power of 2
- sys_clk  in  1  clock, all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot grant; the pair is accepted when valid and ready are both high
- req_a, req_b  in  NREQ*W  operand pairs; lane i at bits [i*W +: W]
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: result for requester i
- rsp_data  out  W  result, shared by all lanes
- rsp_flag  out  3  multiplier flag for the result
- mul_a_tdata, mul_b_tdata  out  W  operands to the multiplier
- mul_a_tvalid, mul_b_tvalid  out  1  always driven identically
- mul_a_tready, mul_b_tready  in  1  multiplier ready signals
- mul_result_tdata  in  W  multiplier result
- mul_result_tvalid  in  1  result valid; no backpressure
- mul_flag  in  3  multiplier flag
- busy  out  1  issue register valid, or inflight ≠ 0
- err_orphan  out  1  sticky: a result arrived with the tag FIFO empty

## Operation
- **Issue register** (iv, ia, ib, iid). It drives mul_*_tdata, and iv drives both tvalids.
- **Handoff** occurs only when iv && mul_a_tready && mul_b_tready in the same cycle. Operands stay stable until handoff.
- **Slot free** when: (!iv || handoff) && inflight < DEPTH.
  - inflight counts the issue register plus the tag FIFO occupancy.
- **Grant** (combinational):
  - Applies when a slot is free.
  - Scan starts at lane (last+1) mod NREQ.
  - The first lane with req_valid gets req_ready; at most one bit is set.
  - On acceptance: load the issue register, and set last to the granted lane.
- **Tag FIFO**:
  - DEPTH entries, clog2(NREQ)-bit ids.
  - On handoff, push iid.
  - On mul_result_tvalid, pop the head.
  - Next cycle, register rsp_valid[head]=1, rsp_data=mul_result_tdata, rsp_flag=mul_flag.
- **inflight** +1 on request accept, -1 on result pop. If both happen in the same cycle, it is unchanged.
- **Orphan result**: mul_result_tvalid while the FIFO is empty.
  - Drop it; no rsp_valid.
  - Set err_orphan; it stays set until sys_rst.
- **Full FIFO**: no push can occur, because the inflight bound blocks the grant.
- **Ordering**: results are assumed in issue order; the multiplier is in-order by construction.

## Timing
- **Reset values**: req_ready=0, rsp_valid=0, rsp_data=0, rsp_flag=0, mul_*_tvalid=0, mul_*_tdata=0, busy=0, err_orphan=0, last=NREQ-1 (first grant is lane 0), FIFO empty, inflight=0.
- **Latency**:
  - Accept at cycle N → mul tvalid at N+1.
  - Multiplier result at cycle M → rsp_valid at M+1.
- **Throughput**: one accept per cycle when the multiplier is always ready and inflight < DEPTH.
- **Fairness**: with all lanes requesting, grants rotate 0,1,…,NREQ-1,0. No lane waits more than NREQ-1 grants.
- **Back-to-back**: accept and handoff are allowed in the same cycle (register refills).
- **Simultaneous push and pop**, including with the FIFO at DEPTH-1, keeps both occupancy and ordering correct.
- **Reset mid-operation**:
  - Clears all state immediately (asynchronous).
  - Pending operations are lost, with no rsp pulse.
  - Late results set err_orphan.

## Test plan
- **Single op**: lane 0 issues a=16'h3c00, b=16'h4000; bench model is a 3-cycle multiplier, always ready → mul_a_tdata=16'h3c00 at N+1; rsp_valid=4'b0001, rsp_data=16'h4000, rsp_flag from model, 1-cycle pulse; busy returns to 0.
- **Round-robin**: all four lanes hold valid for 8 accepts → grant order 0,1,2,3,0,1,2,3; each lane gets 2 responses with matching products (e.g., lane 2 with 16'h2e66×16'h068e matches the model), in order.
- **Credit limit**: multiplier ready, latency 10, all lanes requesting → at most 4 accepts, then req_ready=0 until the first result pops; then grants resume at 1 per result.
- **Ready stall**: mul_a_tready=1, mul_b_tready=0 for 5 cycles → operands are held stable, no push, no new grant. Both ready → handoff, then the next grant in the same cycle.
- **Simultaneous push/pop at inflight=DEPTH**: sustained traffic, latency 3 → inflight stays at ≤ 4 with no lost or duplicated tags; the response id sequence equals the grant sequence.
- **Reset/orphan**: assert sys_rst with 3 ops in flight, then inject mul_result_tvalid after release → all outputs reset, no rsp_valid, err_orphan=1 until the next reset.
